// File: rtl/lifo_arbiter_if.sv
// lifo_req_if: one requester's connection to the shared LIFO arbiter.
//
// Handshake: req/op/wdata are presented by the requester and held until gnt
// is seen high in the same cycle; the operation is consumed on that cycle's
// rising edge. Exactly one cycle later rvalid pulses for one cycle, carrying
// rdata (pop data for a legal pop, else 0) and rerr (op was illegal, not
// issued). There is no backpressure on the response path.
//
// Signals:
//   req    requester -> arbiter  request valid
//   op     requester -> arbiter  0 = push, 1 = pop
//   wdata  requester -> arbiter  push data
//   gnt    arbiter -> requester  combinational grant
//   rvalid arbiter -> requester  registered response strobe
//   rdata  arbiter -> requester  pop data
//   rerr   arbiter -> requester  illegal-op flag
interface lifo_req_if #(
    parameter int WIDTH = 8
);
    logic             req;
    logic             op;
    logic [WIDTH-1:0] wdata;
    logic             gnt;
    logic             rvalid;
    logic [WIDTH-1:0] rdata;
    logic             rerr;

    // Requester side.
    modport master (
        output req, op, wdata,
        input  gnt, rvalid, rdata, rerr
    );

    // Arbiter side.
    modport slave (
        input  req, op, wdata,
        output gnt, rvalid, rdata, rerr
    );
endinterface

// File: rtl/lifo_arbiter.sv
// lifo_arbiter: two-requester round-robin arbiter in front of one LIFO stack.
//
// At most one stack operation is accepted per cycle. Legality is checked
// against a shadow occupancy counter; illegal ops (push when full, pop when
// empty) are still granted but not issued, and are answered with rerr.
//
// Ports:
//   clk       clock, rising edge
//   reset     asynchronous active-high reset (deassertion is expected to be
//             synchronised upstream; the attached stack shares it)
//   a, b      requester interfaces (lifo_req_if.slave)
//   stk_push  combinational push strobe to the stack
//   stk_pop   combinational pop strobe to the stack
//   stk_din   granted requester's wdata, else 0
//   stk_dout  stack read data, registered by the stack on the pop edge
//   level     shadow occupancy, 0..DEPTH
//   full      level == DEPTH
//   empty     level == 0
//   rr_state  priority pointer (0 = A preferred, 1 = B preferred)
module lifo_arbiter #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    lifo_req_if.slave        a,
    lifo_req_if.slave        b,
    output logic             stk_push,
    output logic             stk_pop,
    output logic [WIDTH-1:0] stk_din,
    input  logic [WIDTH-1:0] stk_dout,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty,
    output logic             rr_state
);

    typedef enum logic {
        PREF_A = 1'b0,
        PREF_B = 1'b1
    } rr_t;

    rr_t rr_q, rr_d;

    logic             gnt_a, gnt_b, any_gnt;
    logic             sel_op;
    logic [WIDTH-1:0] sel_wdata;
    logic             op_legal;

    // Response register: one pending response at most.
    logic             rsp_valid;
    logic             rsp_owner;  // 0 = A, 1 = B
    logic             rsp_pop;
    logic             rsp_err;
    logic [WIDTH-1:0] rsp_data;

    // Priority pointer register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q <= PREF_A;
        end else begin
            rr_q <= rr_d;
        end
    end

    // Grant selection and next pointer. Grants are held off during reset so
    // no strobe reaches the stack while it is being cleared.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        rr_d  = rr_q;
        if (!reset) begin
            if (a.req && (!b.req || rr_q == PREF_A)) begin
                gnt_a = 1'b1;
            end else if (b.req) begin
                gnt_b = 1'b1;
            end
        end
        // The loser of this cycle becomes preferred; idle cycles hold.
        if (gnt_a) begin
            rr_d = PREF_B;
        end else if (gnt_b) begin
            rr_d = PREF_A;
        end
    end

    assign any_gnt   = gnt_a | gnt_b;
    assign sel_op    = gnt_b ? b.op    : a.op;
    assign sel_wdata = gnt_b ? b.wdata : a.wdata;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

    // level already reflects every earlier grant, so back-to-back ops are
    // judged correctly without any forwarding.
    assign op_legal = sel_op ? !empty : !full;

    // push and pop are mutually exclusive because sel_op picks one.
    assign stk_push = any_gnt & ~sel_op & op_legal;
    assign stk_pop  = any_gnt &  sel_op & op_legal;
    assign stk_din  = any_gnt ? sel_wdata : '0;

    // Shadow occupancy and response capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level     <= '0;
            rsp_valid <= 1'b0;
            rsp_owner <= 1'b0;
            rsp_pop   <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= any_gnt;
            rsp_owner <= gnt_b;
            rsp_pop   <= any_gnt & sel_op;
            rsp_err   <= any_gnt & ~op_legal;
            if (stk_push) begin
                level <= level + LW'(1);
            end else if (stk_pop) begin
                level <= level - LW'(1);
            end
        end
    end

    // Pop data comes straight from the stack's output register, which it
    // loaded on the same edge that captured the response.
    assign rsp_data = (rsp_valid && rsp_pop && !rsp_err) ? stk_dout : '0;

    assign a.gnt    = gnt_a;
    assign a.rvalid = rsp_valid & ~rsp_owner;
    assign a.rerr   = rsp_valid & ~rsp_owner & rsp_err;
    assign a.rdata  = (rsp_valid && !rsp_owner) ? rsp_data : '0;

    assign b.gnt    = gnt_b;
    assign b.rvalid = rsp_valid & rsp_owner;
    assign b.rerr   = rsp_valid & rsp_owner & rsp_err;
    assign b.rdata  = (rsp_valid && rsp_owner) ? rsp_data : '0;

    assign rr_state = rr_q;

endmodule

// File: tb/tb_lifo_arbiter.sv
// tb_lifo_arbiter: directed bench for lifo_arbiter with a behavioural 8-deep
// stack attached to the stack strobes.
module tb_lifo_arbiter;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int LW    = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lifo_req_if #(.WIDTH(WIDTH)) a_if ();
  lifo_req_if #(.WIDTH(WIDTH)) b_if ();

  logic             stk_push, stk_pop;
  logic [WIDTH-1:0] stk_din, stk_dout;
  logic [LW-1:0]    level;
  logic             full, empty, rr_state;

  int checks = 0;
  int errors = 0;

  lifo_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH), .LW(LW)) dut (
    .clk      (clk),
    .reset    (reset),
    .a        (a_if),
    .b        (b_if),
    .stk_push (stk_push),
    .stk_pop  (stk_pop),
    .stk_din  (stk_din),
    .stk_dout (stk_dout),
    .level    (level),
    .full     (full),
    .empty    (empty),
    .rr_state (rr_state)
  );

  // ---------------- behavioural stack ----------------
  logic [WIDTH-1:0] stk_mem [0:DEPTH-1];
  logic [3:0]       sp;
  logic [3:0]       sp_m1;
  assign sp_m1 = sp - 4'd1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sp       <= 4'd0;
      stk_dout <= '0;
    end else if (stk_push && sp < 4'd8) begin
      stk_mem[sp[2:0]] <= stk_din;
      sp <= sp + 4'd1;
    end else if (stk_pop && sp > 4'd0) begin
      stk_dout <= stk_mem[sp_m1[2:0]];
      sp <= sp_m1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    a_if.req = 1'b0; a_if.op = 1'b0; a_if.wdata = '0;
    b_if.req = 1'b0; b_if.op = 1'b0; b_if.wdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drive_a(input logic op, input logic [WIDTH-1:0] d);
    a_if.req = 1'b1; a_if.op = op; a_if.wdata = d;
  endtask

  task automatic drive_b(input logic op, input logic [WIDTH-1:0] d);
    b_if.req = 1'b1; b_if.op = op; b_if.wdata = d;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    a_if.req = 1'b1; b_if.req = 1'b1;
    #1;
    checks++; if (a_if.gnt !== 1'b0) begin errors++; $display("FAIL rst_a_gnt got %0b exp 0", a_if.gnt); end
    checks++; if (b_if.gnt !== 1'b0) begin errors++; $display("FAIL rst_b_gnt got %0b exp 0", b_if.gnt); end
    checks++; if (stk_push !== 1'b0 || stk_pop !== 1'b0) begin errors++; $display("FAIL rst_strobes got %0b%0b exp 00", stk_push, stk_pop); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", level); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL rst_flags got e%0b f%0b exp e1 f0", empty, full); end
    checks++; if (a_if.rvalid !== 1'b0 || b_if.rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %0b%0b exp 00", a_if.rvalid, b_if.rvalid); end
    checks++; if (a_if.rerr !== 1'b0 || a_if.rdata !== 8'h00) begin errors++; $display("FAIL rst_rsp got err %0b data %h exp 0 00", a_if.rerr, a_if.rdata); end
    checks++; if (rr_state !== 1'b0) begin errors++; $display("FAIL rst_rr got %0b exp 0", rr_state); end
    idle();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_push3();
    logic [WIDTH-1:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b0, vals[i]);
      #1;
      checks++; if (a_if.gnt !== 1'b1) begin errors++; $display("FAIL push3_gnt[%0d] got %0b exp 1", i, a_if.gnt); end
      checks++; if (stk_push !== 1'b1 || stk_din !== vals[i]) begin errors++; $display("FAIL push3_stk[%0d] got push %0b din %h exp 1 %h", i, stk_push, stk_din, vals[i]); end
      tick();
      checks++; if (a_if.rvalid !== 1'b1 || a_if.rerr !== 1'b0 || b_if.rvalid !== 1'b0) begin errors++; $display("FAIL push3_rsp[%0d] got av %0b ae %0b bv %0b exp 1 0 0", i, a_if.rvalid, a_if.rerr, b_if.rvalid); end
      checks++; if (level !== LW'(i + 1)) begin errors++; $display("FAIL push3_level[%0d] got %0d exp %0d", i, level, i + 1); end
    end
    idle();
    tick();
    checks++; if (a_if.rvalid !== 1'b0) begin errors++; $display("FAIL push3_idle_rvalid got %0b exp 0", a_if.rvalid); end
  endtask

  task automatic test_pop3();
    logic [WIDTH-1:0] exp_d [3];
    exp_d[0] = 8'h33; exp_d[1] = 8'h22; exp_d[2] = 8'h11;
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, 8'h00);
      #1;
      checks++; if (a_if.gnt !== 1'b1 || stk_pop !== 1'b1 || stk_push !== 1'b0) begin errors++; $display("FAIL pop3_grant[%0d] got g %0b pop %0b push %0b exp 1 1 0", i, a_if.gnt, stk_pop, stk_push); end
      tick();
      checks++; if (a_if.rvalid !== 1'b1 || a_if.rerr !== 1'b0) begin errors++; $display("FAIL pop3_rsp[%0d] got v %0b e %0b exp 1 0", i, a_if.rvalid, a_if.rerr); end
      checks++; if (a_if.rdata !== exp_d[i]) begin errors++; $display("FAIL pop3_rdata[%0d] got %h exp %h", i, a_if.rdata, exp_d[i]); end
      checks++; if (level !== LW'(2 - i)) begin errors++; $display("FAIL pop3_level[%0d] got %0d exp %0d", i, level, 2 - i); end
    end
    idle();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pop3_empty got %0b exp 1", empty); end
  endtask

  task automatic test_alternate();
    logic exp_a;
    apply_reset();
    drive_a(1'b0, 8'hA5);
    drive_b(1'b0, 8'h5B);
    for (int i = 0; i < 4; i++) begin
      exp_a = ((i % 2) == 0);
      #1;
      checks++; if (a_if.gnt !== exp_a || b_if.gnt !== !exp_a) begin errors++; $display("FAIL alt_gnt[%0d] got a%0b b%0b exp a%0b", i, a_if.gnt, b_if.gnt, exp_a); end
      checks++; if (stk_din !== (exp_a ? 8'hA5 : 8'h5B)) begin errors++; $display("FAIL alt_din[%0d] got %h", i, stk_din); end
      tick();
      checks++; if (a_if.rvalid !== exp_a || b_if.rvalid !== !exp_a) begin errors++; $display("FAIL alt_route[%0d] got a%0b b%0b exp a%0b", i, a_if.rvalid, b_if.rvalid, exp_a); end
      checks++; if (level !== LW'(i + 1)) begin errors++; $display("FAIL alt_level[%0d] got %0d exp %0d", i, level, i + 1); end
    end
    // Last grant went to B, so A is preferred again.
    checks++; if (rr_state !== 1'b0) begin errors++; $display("FAIL alt_rr got %0b exp 0", rr_state); end
    idle();
    drive_b(1'b1, 8'h00);
    #1;
    checks++; if (b_if.gnt !== 1'b1 || stk_pop !== 1'b1) begin errors++; $display("FAIL alt_pop_grant got g %0b pop %0b exp 1 1", b_if.gnt, stk_pop); end
    tick();
    idle();
    checks++; if (b_if.rdata !== 8'h5B || a_if.rvalid !== 1'b0 || a_if.rdata !== 8'h00) begin errors++; $display("FAIL alt_pop_rsp got b %h av %0b ad %h exp 5b 0 00", b_if.rdata, a_if.rvalid, a_if.rdata); end
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive_a(1'b0, 8'h40 + 8'(i));
      tick();
    end
    checks++; if (level !== 4'd8 || full !== 1'b1) begin errors++; $display("FAIL full_fill got level %0d full %0b exp 8 1", level, full); end
    drive_a(1'b0, 8'h99);
    #1;
    checks++; if (a_if.gnt !== 1'b1 || stk_push !== 1'b0) begin errors++; $display("FAIL full_push9 got g %0b push %0b exp 1 0", a_if.gnt, stk_push); end
    tick();
    checks++; if (a_if.rvalid !== 1'b1 || a_if.rerr !== 1'b1 || a_if.rdata !== 8'h00) begin errors++; $display("FAIL full_rsp9 got v %0b e %0b d %h exp 1 1 00", a_if.rvalid, a_if.rerr, a_if.rdata); end
    checks++; if (level !== 4'd8 || full !== 1'b1) begin errors++; $display("FAIL full_level9 got %0d full %0b exp 8 1", level, full); end
    drive_a(1'b1, 8'h00);
    #1;
    checks++; if (stk_pop !== 1'b1) begin errors++; $display("FAIL full_pop_strobe got %0b exp 1", stk_pop); end
    tick();
    idle();
    checks++; if (a_if.rdata !== 8'h47 || a_if.rerr !== 1'b0) begin errors++; $display("FAIL full_pop_rsp got d %h e %0b exp 47 0", a_if.rdata, a_if.rerr); end
    checks++; if (level !== 4'd7 || full !== 1'b0) begin errors++; $display("FAIL full_pop_level got %0d full %0b exp 7 0", level, full); end
  endtask

  task automatic test_empty();
    apply_reset();
    drive_b(1'b1, 8'h00);
    #1;
    checks++; if (b_if.gnt !== 1'b1 || stk_pop !== 1'b0) begin errors++; $display("FAIL empty_pop got g %0b pop %0b exp 1 0", b_if.gnt, stk_pop); end
    tick();
    checks++; if (b_if.rvalid !== 1'b1 || b_if.rerr !== 1'b1 || b_if.rdata !== 8'h00) begin errors++; $display("FAIL empty_rsp got v %0b e %0b d %h exp 1 1 00", b_if.rvalid, b_if.rerr, b_if.rdata); end
    checks++; if (level !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL empty_level got %0d e %0b exp 0 1", level, empty); end
    drive_b(1'b0, 8'h5A);
    #1;
    checks++; if (stk_push !== 1'b1 || stk_din !== 8'h5A) begin errors++; $display("FAIL empty_push got push %0b din %h exp 1 5a", stk_push, stk_din); end
    tick();
    idle();
    checks++; if (b_if.rvalid !== 1'b1 || b_if.rerr !== 1'b0 || level !== 4'd1 || empty !== 1'b0) begin errors++; $display("FAIL empty_push_rsp got v %0b e %0b lvl %0d empty %0b exp 1 0 1 0", b_if.rvalid, b_if.rerr, level, empty); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    drive_a(1'b0, 8'h77);
    tick();
    drive_a(1'b1, 8'h00);
    #1;
    checks++; if (stk_pop !== 1'b1) begin errors++; $display("FAIL rmid_pop got %0b exp 1", stk_pop); end
    tick();
    // Response is pending now; pull reset in the middle of the response cycle.
    reset = 1'b1;
    #1;
    checks++; if (a_if.rvalid !== 1'b0 || a_if.rdata !== 8'h00) begin errors++; $display("FAIL rmid_async_rsp got v %0b d %h exp 0 00", a_if.rvalid, a_if.rdata); end
    checks++; if (a_if.gnt !== 1'b0 || stk_pop !== 1'b0 || stk_push !== 1'b0) begin errors++; $display("FAIL rmid_async_gnt got g %0b pop %0b push %0b exp 000", a_if.gnt, stk_pop, stk_push); end
    checks++; if (level !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL rmid_async_level got %0d e %0b f %0b exp 0 1 0", level, empty, full); end
    idle();
    tick();
    reset = 1'b0;
    tick();
    checks++; if (a_if.rvalid !== 1'b0 || b_if.rvalid !== 1'b0 || level !== 4'd0) begin errors++; $display("FAIL rmid_after got av %0b bv %0b lvl %0d exp 0 0 0", a_if.rvalid, b_if.rvalid, level); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    idle();
    #2;
    test_reset();
    test_push3();
    test_pop3();
    test_alternate();
    test_full();
    test_empty();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
